md_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation, stalls the pipeline while it runs a 32-step shift-add or restoring-divide sequence, then presents the result for one cycle so the E/M register captures it.
- The hazard unit ORs StallE_o into the F/D/E stall enables.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_sequencer_if.sv | 24 ++
 rtl/md_datapath.sv | 94 +++++++++
 rtl/md_sequencer.sv | 97 +++++++++
 tb/tb_md_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package md_pkg;

   localparam int MD_XLEN  = 32;
   localparam int MD_CNT_W = 6;
   localparam int MD_STEPS = MD_XLEN;

   localparam logic [MD_XLEN-1:0] DIV0_QUOT = {MD_XLEN{1'b1}};
   localparam logic [MD_XLEN-1:0] OVF_QUOT  = {1'b1, {(MD_XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } md_state_t;

   function automatic logic is_div(md_op_t op);
      logic [2:0] w_bits;
      w_bits = op;
      return w_bits[2];
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface md_sequencer_if import md_pkg::*; #(parameter int XLEN = MD_XLEN);

   logic            StartE_i;
   md_op_t          OpE_i;
   logic [XLEN-1:0] SrcAE_i;
   logic [XLEN-1:0] SrcBE_i;
   logic            FlushE_i;
   logic [XLEN-1:0] ResultE_o;
   logic            DoneE_o;
   logic            BusyE_o;
   logic            StallE_o;

   modport master (
      output StartE_i, OpE_i, SrcAE_i, SrcBE_i, FlushE_i,
      input  ResultE_o, DoneE_o, BusyE_o, StallE_o
   );

   modport slave (
      input  StartE_i, OpE_i, SrcAE_i, SrcBE_i, FlushE_i,
      output ResultE_o, DoneE_o, BusyE_o, StallE_o
   );

endinterface

// File: rtl/md_datapath.sv
// Operand, shift-add / restoring-divide accumulator and sign-corrected result
// register, sequenced by load/prep/step/finish strobes.
module md_datapath import md_pkg::*; #(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_prep,
   input  logic            i_step,
   input  logic            i_fin,
   input  logic            i_div0,
   input  logic            i_ovf,
   input  md_op_t          i_op,
   input  logic [XLEN-1:0] i_src_a,
   input  logic [XLEN-1:0] i_src_b,
   output logic [XLEN-1:0] o_a,
   output logic [XLEN-1:0] o_b,
   output logic [XLEN-1:0] o_result
);

   logic [XLEN-1:0]   r_a, r_b, r_bm, r_result;
   logic [2*XLEN-1:0] r_acc;
   logic              r_neg;

   logic [2:0]        w_opb;
   logic              w_div, w_a_neg, w_b_neg, w_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_dw, w_word;
   logic [XLEN:0]     w_sum, w_trial;
   logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;

   always_comb begin
      w_opb   = i_op;
      w_div   = is_div(i_op);
      w_a_neg = r_a[XLEN-1] & (w_div ? !w_opb[0] : (i_op == OP_MULH || i_op == OP_MULHSU));
      w_b_neg = r_b[XLEN-1] & (w_div ? !w_opb[0] : (i_op == OP_MULH));
      w_a_mag = w_a_neg ? -r_a : r_a;
      w_b_mag = w_b_neg ? -r_b : r_b;
      // remainder takes the dividend's sign; everything else the xor of both
      w_neg   = (w_div && w_opb[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

      // multiply: acc = {partial high, remaining multiplier bits}
      w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_bm} : {(XLEN+1){1'b0}});
      w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
      // divide: acc = {partial remainder, dividend bits shifting into quotient}
      w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_bm};
      w_div_nxt = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      w_acc_nxt = w_div ? w_div_nxt : w_mul_nxt;

      w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
      w_dw   = w_opb[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];

      if (i_div0)
         w_word = w_opb[1] ? r_a : DIV0_QUOT;
      else if (i_ovf)
         w_word = w_opb[1] ? {XLEN{1'b0}} : OVF_QUOT;
      else if (w_div)
         w_word = r_neg ? -w_dw : w_dw;
      else
         w_word = (i_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_bm     <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         if (i_load) begin
            r_a <= i_src_a;
            r_b <= i_src_b;
         end
         if (i_prep) begin
            r_acc <= {{XLEN{1'b0}}, w_a_mag};
            r_bm  <= w_b_mag;
            r_neg <= w_neg;
         end else if (i_step) begin
            r_acc <= w_acc_nxt;
         end
         // finish coincides with the last step, so the result uses the stepped value
         if (i_fin)
            r_result <= w_word;
      end
   end

   assign o_a      = r_a;
   assign o_b      = r_b;
   assign o_result = r_result;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: FSM, step counter, pipeline stall handshake and
// divide-by-zero / signed-overflow shortcuts.
module md_sequencer import md_pkg::*; #(
   parameter int XLEN  = MD_XLEN,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   md_sequencer_if.slave  bus
);

   md_state_t        r_state, w_nxt;
   logic [CNT_W-1:0] r_cnt;
   md_op_t           r_op;

   logic [2:0]       w_opb;
   logic             w_accept, w_prep, w_step, w_fin;
   logic             w_div0, w_ovf;
   logic [XLEN-1:0]  w_a, w_b;

   always_comb begin
      w_opb  = r_op;
      w_div0 = is_div(r_op) && (w_b == '0);
      w_ovf  = is_div(r_op) && !w_opb[0] && (w_a == OVF_QUOT) && (w_b == DIV0_QUOT);
   end

   always_comb begin
      w_nxt    = r_state;
      w_accept = 1'b0;
      w_prep   = 1'b0;
      w_step   = 1'b0;
      w_fin    = 1'b0;
      case (r_state)
         IDLE: if (bus.StartE_i && !bus.FlushE_i) begin
            w_accept = 1'b1;
            w_nxt    = PREP;
         end
         PREP: if (bus.FlushE_i) begin
            w_nxt = IDLE;
         end else begin
            w_prep = 1'b1;
            w_fin  = w_div0 | w_ovf;
            w_nxt  = (w_div0 | w_ovf) ? FIN : RUN;
         end
         RUN: if (bus.FlushE_i) begin
            w_nxt = IDLE;
         end else begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_fin = 1'b1;
               w_nxt = FIN;
            end
         end
         FIN:     w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= OP_MUL;
      end else begin
         r_state <= w_nxt;
         if (w_accept)
            r_op <= bus.OpE_i;
         if (w_prep)
            r_cnt <= CNT_W'(MD_STEPS);
         else if (w_step)
            r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   md_datapath #(.XLEN(XLEN)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_prep   (w_prep),
      .i_step   (w_step),
      .i_fin    (w_fin),
      .i_div0   (w_div0),
      .i_ovf    (w_ovf),
      .i_op     (r_op),
      .i_src_a  (bus.SrcAE_i),
      .i_src_b  (bus.SrcBE_i),
      .o_a      (w_a),
      .o_b      (w_b),
      .o_result (bus.ResultE_o)
   );

   // stall drops in FIN so the E/M register captures the result that cycle
   assign bus.DoneE_o  = (r_state == FIN);
   assign bus.BusyE_o  = (r_state != IDLE);
   assign bus.StallE_o = w_accept | (r_state == PREP) | (r_state == RUN);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: behavioural timing/result model checked every
// cycle, plus literal expectations per directed vector.
module tb_md_sequencer;
   import md_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   md_sequencer_if #(.XLEN(32)) bus ();

   md_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // model state: accept cycle, done cycle, last busy cycle, expected/held result
   int          m_t0   = -100;
   int          m_tdone = -100;
   int          m_tend = -100;
   logic [31:0] m_exp  = '0;
   logic [31:0] m_hold = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_special(md_op_t op, logic [31:0] a, logic [31:0] b);
      if (!(op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] ref_res(md_op_t op, logic [31:0] a, logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (op)
         OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (is_special(op, a, b)) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 32'd0) return a;
            if (is_special(op, a, b)) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         OP_REMU:   return (b == 32'd0) ? a : a % b;
         default:   return 32'd0;
      endcase
   endfunction

   // single compare process against the model
   always @(negedge clk) begin
      if (rst) begin
         chk1("rst_done", bus.DoneE_o, 1'b0);
         chk1("rst_busy", bus.BusyE_o, 1'b0);
         chk1("rst_stall", bus.StallE_o, 1'b0);
         chk("rst_result", bus.ResultE_o, 32'd0);
      end else begin
         if (cyc == m_tdone && cyc <= m_tend) m_hold = m_exp;
         chk1("cmp_done", bus.DoneE_o, cyc == m_tdone && cyc <= m_tend);
         chk1("cmp_busy", bus.BusyE_o, cyc > m_t0 && cyc <= m_tend);
         chk1("cmp_stall", bus.StallE_o, cyc >= m_t0 && cyc <= m_tend && cyc != m_tdone);
         chk("cmp_result", bus.ResultE_o, m_hold);
      end
   end

   // Start in the current cycle; returns in the cycle after FIN (or after the flush)
   task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input bit hold, input int flush_at);
      logic [31:0] prev;
      prev = m_hold;
      bus.StartE_i = 1'b1;
      bus.OpE_i    = op;
      bus.SrcAE_i  = a;
      bus.SrcBE_i  = b;
      m_t0    = cyc;
      m_tdone = cyc + (is_special(op, a, b) ? 2 : 34);
      m_tend  = (flush_at >= 0) ? cyc + flush_at : m_tdone;
      m_exp   = ref_res(op, a, b);
      while (cyc < m_tend) begin
         @(posedge clk); #1;
         if (!hold) bus.StartE_i = 1'b0;
         bus.OpE_i    = md_op_t'(3'($urandom_range(0, 7)));
         bus.SrcAE_i  = $urandom;
         bus.SrcBE_i  = $urandom;
         bus.FlushE_i = (flush_at >= 0) && (cyc == m_tend);
      end
      if (flush_at < 0) begin
         chk1("fin_done", bus.DoneE_o, 1'b1);
         chk("fin_latency", 32'(cyc - m_t0), is_special(op, a, b) ? 32'd2 : 32'd34);
         chk("fin_result", bus.ResultE_o, lit);
      end
      @(posedge clk); #1;
      bus.StartE_i = 1'b0;
      bus.FlushE_i = 1'b0;
      if (flush_at >= 0) begin
         chk1("flush_busy", bus.BusyE_o, 1'b0);
         chk1("flush_stall", bus.StallE_o, 1'b0);
         chk("flush_result", bus.ResultE_o, prev);
      end
   endtask

   typedef struct {
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lit;
      bit          hold;
   } vec_t;

   vec_t vecs [15];

   initial begin
      vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
      vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0};
      vecs[5]  = '{OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b1};
      vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'h0000_000E, 1'b0};
      vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'h0000_0002, 1'b0};
      vecs[8]  = '{OP_DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF, 1'b0};
      vecs[9]  = '{OP_REMU,   32'h1234,       32'd0,         32'h0000_1234, 1'b1};
      vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
      vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[12] = '{OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b0};
      vecs[13] = '{OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b0};
      vecs[14] = '{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

      bus.StartE_i = 1'b0;
      bus.OpE_i    = OP_MUL;
      bus.SrcAE_i  = '0;
      bus.SrcBE_i  = '0;
      bus.FlushE_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("reset_busy", bus.BusyE_o, 1'b0);
      chk("reset_result", bus.ResultE_o, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // back-to-back: each op starts in the cycle after the previous FIN
      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lit, vecs[i].hold, -1);

      // flush in cycle 10 of a DIV, then a MUL started in cycle 12
      run_op(OP_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, 10);
      @(posedge clk); #1;
      run_op(OP_MUL, 32'd12345, 32'd1000, 32'h00BC_5EA8, 1'b0, -1);

      // async reset mid-RUN with StartE_i held during busy
      bus.StartE_i = 1'b1;
      bus.OpE_i    = OP_DIV;
      bus.SrcAE_i  = 32'd1000;
      bus.SrcBE_i  = 32'd3;
      m_t0    = cyc;
      m_tdone = cyc + 34;
      m_tend  = m_tdone;
      m_exp   = ref_res(OP_DIV, 32'd1000, 32'd3);
      repeat (20) @(posedge clk);
      #3;
      rst          = 1'b1;
      bus.StartE_i = 1'b0;
      m_t0    = -100;
      m_tdone = -100;
      m_tend  = -100;
      m_hold  = '0;
      #1;
      chk1("arst_done", bus.DoneE_o, 1'b0);
      chk1("arst_busy", bus.BusyE_o, 1'b0);
      chk1("arst_stall", bus.StallE_o, 1'b0);
      chk("arst_result", bus.ResultE_o, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1, -1);
      run_op(OP_REM, 32'd1000, 32'hFFFF_FFF9, 32'd6, 1'b0, -1);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
